// File: rtl/request_vote_pkg.sv
// Shared types, default parameters and width helper for the request vote block.
package request_vote_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAKE  = 3'd1,
    ST_ON    = 3'd2,
    ST_HOLD  = 3'd3,
    ST_SLEEP = 3'd4,
    ST_FAULT = 3'd5
  } vote_state_e;

  localparam int unsigned DEF_NUM_VOTERS     = 4;
  localparam int unsigned DEF_HOLD_CYCLES    = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;
  localparam int unsigned TIMER_W            = 16;

  // Bits needed to hold a count of 0..n.
  function automatic int unsigned count_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/request_module_timer.sv
// Loadable 16-bit down-counter that saturates at zero; shared by hold and timeout use.
module request_module_timer
  import request_vote_pkg::*;
(
  input  logic               clock,
  input  logic               sync_reset,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_load_value,
  output logic               o_zero
);

  logic [TIMER_W-1:0] r_count;

  // Load has priority; otherwise count down and stick at zero.
  always_ff @(posedge clock) begin
    if (sync_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - TIMER_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/request_module_vote.sv
// Power vote aggregator: keeps a downstream target awake while any requester votes,
// lingers before power-down, and flags timeouts and handshake protocol errors.
module request_module_vote
  import request_vote_pkg::*;
#(
  parameter int unsigned NUM_VOTERS     = DEF_NUM_VOTERS,
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                                 clock,
  input  logic                                 sync_reset,
  input  logic [NUM_VOTERS-1:0]                vote_request,
  output logic [NUM_VOTERS-1:0]                vote_ready,
  output logic                                 target_request,
  input  logic                                 target_ready,
  input  logic                                 target_silent,
  input  logic                                 target_starting,
  input  logic                                 target_stopping,
  output logic [count_width(NUM_VOTERS)-1:0]   active_count,
  output logic                                 fault,
  input  logic                                 fault_clear
);

  localparam int unsigned CNT_W = count_width(NUM_VOTERS);

  // The zero flag rises on the last cycle of a timed state, so the timer is
  // loaded with N-1 to give exactly N cycles in that state.
  localparam logic [TIMER_W-1:0] HOLD_LOAD    = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);

  vote_state_e           r_state;
  vote_state_e           w_next;
  logic [NUM_VOTERS-1:0] r_vote_ready;
  logic                  r_target_request;
  logic [CNT_W-1:0]      r_active_count;
  logic                  r_fault;

  logic                  w_any_vote;
  logic [CNT_W-1:0]      w_pop;
  logic                  w_timer_load;
  logic [TIMER_W-1:0]    w_timer_value;
  logic                  w_timer_zero;
  logic                  w_unused;

  // Starting/stopping status is informational only.
  assign w_unused = ^{target_starting, target_stopping};

  assign w_any_vote = |vote_request;

  // Population count of the current votes.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < int'(NUM_VOTERS); i++) begin
      w_pop = w_pop + CNT_W'(vote_request[i]);
    end
  end

  request_module_timer u_timer (
    .clock        (clock),
    .sync_reset   (sync_reset),
    .i_load       (w_timer_load),
    .i_load_value (w_timer_value),
    .o_zero       (w_timer_zero)
  );

  // Next-state decode and timer load requests; protocol errors override normal flow.
  always_comb begin
    w_next        = r_state;
    w_timer_load  = 1'b0;
    w_timer_value = '0;
    if (r_state == ST_FAULT) begin
      if (fault_clear) begin
        w_next = ST_IDLE;
      end
    end else if (target_ready && target_silent) begin
      w_next = ST_FAULT;
    end else if (!target_ready && (r_state == ST_ON || r_state == ST_HOLD)) begin
      w_next = ST_FAULT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_vote && target_silent) begin
            w_next        = ST_WAKE;
            w_timer_load  = 1'b1;
            w_timer_value = TIMEOUT_LOAD;
          end
        end
        ST_WAKE: begin
          if (target_ready) begin
            w_next = ST_ON;
          end else if (w_timer_zero) begin
            w_next = ST_FAULT;
          end
        end
        ST_ON: begin
          if (!w_any_vote) begin
            w_next        = ST_HOLD;
            w_timer_load  = 1'b1;
            w_timer_value = HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          // A vote arriving together with expiry keeps the target on.
          if (w_any_vote) begin
            w_next = ST_ON;
          end else if (w_timer_zero) begin
            w_next        = ST_SLEEP;
            w_timer_load  = 1'b1;
            w_timer_value = TIMEOUT_LOAD;
          end
        end
        ST_SLEEP: begin
          if (target_silent) begin
            w_next = ST_IDLE;
          end else if (w_timer_zero) begin
            w_next = ST_FAULT;
          end
        end
        default: begin
          w_next = ST_FAULT;
        end
      endcase
    end
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clock) begin
    if (sync_reset) begin
      r_state          <= ST_IDLE;
      r_target_request <= 1'b0;
      r_vote_ready     <= '0;
      r_active_count   <= '0;
      r_fault          <= 1'b0;
    end else begin
      r_state          <= w_next;
      r_target_request <= (w_next == ST_WAKE) || (w_next == ST_ON) || (w_next == ST_HOLD);
      r_vote_ready     <= (r_state == ST_ON && w_next == ST_ON) ? vote_request : '0;
      r_active_count   <= w_pop;
      r_fault          <= (w_next == ST_FAULT);
    end
  end

  assign vote_ready     = r_vote_ready;
  assign target_request = r_target_request;
  assign active_count   = r_active_count;
  assign fault          = r_fault;

endmodule

// File: tb/tb_request_module_vote.sv
// Directed self-checking bench for request_module_vote.
module tb_request_module_vote;

  localparam int unsigned NV = 4;

  logic       clock = 1'b0;
  logic       sync_reset;
  logic [3:0] vote_request;
  logic [3:0] vote_ready;
  logic       target_request;
  logic       target_ready;
  logic       target_silent;
  logic       target_starting;
  logic       target_stopping;
  logic [2:0] active_count;
  logic       fault;
  logic       fault_clear;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  request_module_vote #(
    .NUM_VOTERS     (NV),
    .HOLD_CYCLES    (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock           (clock),
    .sync_reset      (sync_reset),
    .vote_request    (vote_request),
    .vote_ready      (vote_ready),
    .target_request  (target_request),
    .target_ready    (target_ready),
    .target_silent   (target_silent),
    .target_starting (target_starting),
    .target_stopping (target_stopping),
    .active_count    (active_count),
    .fault           (fault),
    .fault_clear     (fault_clear)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reset, then wake the target with vote v and sit in ON with grants valid.
  task automatic bring_up(input logic [3:0] v);
    sync_reset = 1'b1; target_ready = 1'b0; target_silent = 1'b1;
    fault_clear = 1'b0; vote_request = v;
    step();
    sync_reset = 1'b0;
    step();
    target_ready = 1'b1; target_silent = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    sync_reset = 1'b1; vote_request = 4'b1111; target_ready = 1'b0;
    target_silent = 1'b1; fault_clear = 1'b0;
    target_starting = 1'b0; target_stopping = 1'b0;
    step(); step();
    tests++; if (target_request !== 1'b0) begin fails++; $display("FAIL reset_treq got %b exp 0", target_request); end
    tests++; if (vote_ready !== 4'b0000) begin fails++; $display("FAIL reset_vready got %b exp 0000", vote_ready); end
    tests++; if (active_count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", active_count); end
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault got %b exp 0", fault); end
  endtask

  task automatic test_grant();
    sync_reset = 1'b1; vote_request = 4'b0000; step();
    sync_reset = 1'b0; vote_request = 4'b0001; target_silent = 1'b1; target_ready = 1'b0;
    step();
    tests++; if (target_request !== 1'b1) begin fails++; $display("FAIL wake_treq got %b exp 1", target_request); end
    tests++; if (active_count !== 3'd1) begin fails++; $display("FAIL wake_count got %0d exp 1", active_count); end
    target_ready = 1'b1; target_silent = 1'b0; target_starting = 1'b1;
    step();
    target_starting = 1'b0;
    tests++; if (vote_ready !== 4'b0000) begin fails++; $display("FAIL on_entry_vready got %b exp 0000", vote_ready); end
    step();
    tests++; if (vote_ready !== 4'b0001) begin fails++; $display("FAIL on_vready got %b exp 0001", vote_ready); end
    vote_request = 4'b0101;
    step();
    tests++; if (vote_ready !== 4'b0101) begin fails++; $display("FAIL on_vready2 got %b exp 0101", vote_ready); end
    tests++; if (active_count !== 3'd2) begin fails++; $display("FAIL on_count2 got %0d exp 2", active_count); end
  endtask

  task automatic test_hold_sleep();
    int high = 0;
    bring_up(4'b0101);
    vote_request = 4'b0000;
    step();
    tests++; if (vote_ready !== 4'b0000) begin fails++; $display("FAIL hold_vready got %b exp 0000", vote_ready); end
    for (int i = 0; i < 20 && target_request === 1'b1; i++) begin
      high++;
      step();
    end
    tests++; if (high != 16) begin fails++; $display("FAIL hold_len got %0d exp 16", high); end
    tests++; if (target_request !== 1'b0) begin fails++; $display("FAIL sleep_treq got %b exp 0", target_request); end
    target_ready = 1'b0; target_stopping = 1'b1;
    step();
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL sleep_fault got %b exp 0", fault); end
    target_stopping = 1'b0; target_silent = 1'b1;
    step();
    vote_request = 4'b0010;
    step();
    tests++; if (target_request !== 1'b1) begin fails++; $display("FAIL idle_rewake got %b exp 1", target_request); end
  endtask

  task automatic test_hold_revote();
    bring_up(4'b0001);
    vote_request = 4'b0000;
    step();
    for (int i = 0; i < 9; i++) step();
    vote_request = 4'b1000;
    step();
    tests++; if (target_request !== 1'b1) begin fails++; $display("FAIL revote_treq got %b exp 1", target_request); end
    tests++; if (vote_ready !== 4'b0000) begin fails++; $display("FAIL revote_vready0 got %b exp 0000", vote_ready); end
    step();
    tests++; if (vote_ready !== 4'b1000) begin fails++; $display("FAIL revote_vready got %b exp 1000", vote_ready); end
    // Vote arriving on the last hold cycle still wins over expiry.
    bring_up(4'b0001);
    vote_request = 4'b0000;
    step();
    for (int i = 0; i < 15; i++) step();
    vote_request = 4'b0001;
    step();
    tests++; if (target_request !== 1'b1) begin fails++; $display("FAIL expiry_vote_treq got %b exp 1", target_request); end
    step();
    tests++; if (vote_ready !== 4'b0001) begin fails++; $display("FAIL expiry_vote_vready got %b exp 0001", vote_ready); end
  endtask

  task automatic test_wake_timeout();
    int wake = 0;
    sync_reset = 1'b1; step();
    sync_reset = 1'b0; vote_request = 4'b0001; target_silent = 1'b1; target_ready = 1'b0;
    step();
    target_silent = 1'b0;
    for (int i = 0; i < 12 && target_request === 1'b1; i++) begin
      wake++;
      step();
    end
    tests++; if (wake != 8) begin fails++; $display("FAIL wake_len got %0d exp 8", wake); end
    tests++; if (fault !== 1'b1) begin fails++; $display("FAIL timeout_fault got %b exp 1", fault); end
    step();
    tests++; if (fault !== 1'b1) begin fails++; $display("FAIL fault_sticky got %b exp 1", fault); end
    fault_clear = 1'b1;
    step();
    fault_clear = 1'b0;
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL fault_clear got %b exp 0", fault); end
    step();
    tests++; if (target_request !== 1'b0) begin fails++; $display("FAIL idle_no_silent got %b exp 0", target_request); end
  endtask

  task automatic test_protocol();
    bring_up(4'b0011);
    target_silent = 1'b1;
    step();
    tests++; if (fault !== 1'b1) begin fails++; $display("FAIL proto_fault got %b exp 1", fault); end
    tests++; if (target_request !== 1'b0) begin fails++; $display("FAIL proto_treq got %b exp 0", target_request); end
    tests++; if (vote_ready !== 4'b0000) begin fails++; $display("FAIL proto_vready got %b exp 0000", vote_ready); end
    bring_up(4'b0001);
    target_ready = 1'b0;
    step();
    tests++; if (fault !== 1'b1) begin fails++; $display("FAIL ready_drop_fault got %b exp 1", fault); end
  endtask

  task automatic test_reset_wake();
    sync_reset = 1'b1; step();
    sync_reset = 1'b0; vote_request = 4'b0111; target_silent = 1'b1; target_ready = 1'b0;
    step();
    tests++; if (active_count !== 3'd3) begin fails++; $display("FAIL rw_count got %0d exp 3", active_count); end
    sync_reset = 1'b1;
    step();
    sync_reset = 1'b0;
    tests++; if (target_request !== 1'b0) begin fails++; $display("FAIL rw_treq got %b exp 0", target_request); end
    tests++; if (active_count !== 3'd0) begin fails++; $display("FAIL rw_count0 got %0d exp 0", active_count); end
    step();
    tests++; if (target_request !== 1'b1) begin fails++; $display("FAIL rw_rewake got %b exp 1", target_request); end
    tests++; if (active_count !== 3'd3) begin fails++; $display("FAIL rw_count3 got %0d exp 3", active_count); end
  endtask

  initial begin
    test_reset();
    test_grant();
    test_hold_sleep();
    test_hold_revote();
    test_wake_timeout();
    test_protocol();
    test_reset_wake();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
